// File: rtl/inta_sequencer_pkg.sv
// Shared constants and helpers for the 8259 acknowledge sequencer.
// FSM encodings are plain localparams so legacy tools can consume them.
package inta_sequencer_pkg;

  localparam int unsigned NUM_IR = 8;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StIntPend = 3'd1;
  localparam logic [2:0] StAck1    = 3'd2;
  localparam logic [2:0] StWait2   = 3'd3;
  localparam logic [2:0] StAck2    = 3'd4;

  // Lowest set bit wins if the input is not strictly one-hot.
  function automatic logic [2:0] onehot_to_idx(input logic [NUM_IR-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [NUM_IR-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [NUM_IR-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// CPU-side INT/INTA/data bus between the 8259 sequencer and the processor.
interface inta_sequencer_if;
  import inta_sequencer_pkg::*;

  logic              inta_n;
  logic              int_out;
  logic [NUM_IR-1:0] data_out;
  logic              data_oe;

  modport master (
    output inta_n,
    input  int_out,
    input  data_out,
    input  data_oe
  );

  modport slave (
    input  inta_n,
    output int_out,
    output data_out,
    output data_oe
  );
endinterface

// File: rtl/inta_sequencer_isr_highest_finder.sv
// Finds the highest-priority set ISR bit under rotating priority; the level
// after priority_rotate_i is the highest and the scan wraps around.
module isr_highest_finder
  import inta_sequencer_pkg::*;
(
  input  logic [NUM_IR-1:0] isr_i,
  input  logic [2:0]        priority_rotate_i,
  output logic [NUM_IR-1:0] highest_o
);

  logic       found;
  logic [2:0] idx;

  always_comb begin
    highest_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_IR; i++) begin
      idx = priority_rotate_i + 3'd1 + 3'(i);
      if (!found && isr_i[idx]) begin
        highest_o[idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inta_sequencer.sv
// 8086-mode INTA responder: raises INT, runs the two-pulse acknowledge,
// maintains the ISR (including EOI / auto-EOI) and drives the vector byte.
module inta_sequencer
  import inta_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] interrupt,
  input  logic [2:0]        priority_rotate,
  input  logic [4:0]        vector_base,
  input  logic              auto_eoi,
  input  logic              eoi_valid,
  input  logic              eoi_specific,
  input  logic [2:0]        eoi_level,
  output logic [NUM_IR-1:0] isr,
  output logic [NUM_IR-1:0] clear_irr,
  output logic              freeze,
  inta_sequencer_if.slave   cpu
);

  logic [2:0]        state_q, state_d;
  logic [2:0]        ack_level_q, ack_level_d;
  logic              spurious_q, spurious_d;
  logic              inta_q;
  logic              int_out_q, int_out_d;
  logic              freeze_q, freeze_d;
  logic              data_oe_q, data_oe_d;
  logic [NUM_IR-1:0] data_out_q, data_out_d;
  logic [NUM_IR-1:0] clear_irr_q, clear_irr_d;
  logic [NUM_IR-1:0] isr_q, isr_d;

  logic              fall, rise;
  logic [NUM_IR-1:0] isr_set, aeoi_clr, eoi_clr, highest;

  assign fall = inta_q & ~cpu.inta_n;
  assign rise = ~inta_q & cpu.inta_n;

  isr_highest_finder u_finder (
    .isr_i             (isr_q),
    .priority_rotate_i (priority_rotate),
    .highest_o         (highest)
  );

  always_comb begin
    state_d     = state_q;
    ack_level_d = ack_level_q;
    spurious_d  = spurious_q;
    int_out_d   = int_out_q;
    freeze_d    = freeze_q;
    data_oe_d   = data_oe_q;
    data_out_d  = data_out_q;
    clear_irr_d = '0;
    isr_set     = '0;
    aeoi_clr    = '0;

    unique case (state_q)
      StIdle: begin
        int_out_d = 1'b0;
        if (interrupt != '0) begin
          state_d   = StIntPend;
          int_out_d = 1'b1;
        end
      end
      StIntPend: begin
        if (fall) begin
          state_d   = StAck1;
          freeze_d  = 1'b1;
          int_out_d = 1'b0;
          if (interrupt != '0) begin
            ack_level_d = onehot_to_idx(interrupt);
            spurious_d  = 1'b0;
            isr_set     = idx_to_onehot(ack_level_d);
            clear_irr_d = isr_set;
          end else begin
            // Request vanished on the acknowledge edge: answer with level 7.
            ack_level_d = SPURIOUS_LEVEL;
            spurious_d  = 1'b1;
          end
        end else if (interrupt == '0) begin
          state_d   = StIdle;
          int_out_d = 1'b0;
        end
      end
      StAck1: begin
        data_oe_d = 1'b0;
        if (rise) state_d = StWait2;
      end
      StWait2: begin
        if (fall) begin
          state_d    = StAck2;
          data_oe_d  = 1'b1;
          data_out_d = {vector_base, ack_level_q};
        end
      end
      StAck2: begin
        if (rise) begin
          state_d    = StIdle;
          data_oe_d  = 1'b0;
          data_out_d = '0;
          freeze_d   = 1'b0;
          if (auto_eoi && !spurious_q) aeoi_clr = idx_to_onehot(ack_level_q);
        end
      end
      default: begin
        state_d   = StIdle;
        int_out_d = 1'b0;
        freeze_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    eoi_clr = '0;
    if (eoi_valid) eoi_clr = eoi_specific ? idx_to_onehot(eoi_level) : highest;
    // Applying the set last lets an acknowledge win over a same-bit EOI.
    isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | isr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ack_level_q <= '0;
      spurious_q  <= 1'b0;
      inta_q      <= 1'b1;
      int_out_q   <= 1'b0;
      freeze_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      data_out_q  <= '0;
      clear_irr_q <= '0;
      isr_q       <= '0;
    end else begin
      state_q     <= state_d;
      ack_level_q <= ack_level_d;
      spurious_q  <= spurious_d;
      inta_q      <= cpu.inta_n;
      int_out_q   <= int_out_d;
      freeze_q    <= freeze_d;
      data_oe_q   <= data_oe_d;
      data_out_q  <= data_out_d;
      clear_irr_q <= clear_irr_d;
      isr_q       <= isr_d;
    end
  end

  assign isr          = isr_q;
  assign clear_irr    = clear_irr_q;
  assign freeze       = freeze_q;
  assign cpu.int_out  = int_out_q;
  assign cpu.data_oe  = data_oe_q;
  assign cpu.data_out = data_out_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: acknowledge cycles, EOI flavours,
// spurious handling, set/clear collisions and asynchronous reset.
module tb_inta_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] interrupt;
  logic [2:0] priority_rotate;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic [7:0] isr;
  logic [7:0] clear_irr;
  logic       freeze;

  int n_checks = 0;
  int n_pass   = 0;

  inta_sequencer_if cpu_if ();

  inta_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .interrupt       (interrupt),
    .priority_rotate (priority_rotate),
    .vector_base     (vector_base),
    .auto_eoi        (auto_eoi),
    .eoi_valid       (eoi_valid),
    .eoi_specific    (eoi_specific),
    .eoi_level       (eoi_level),
    .isr             (isr),
    .clear_irr       (clear_irr),
    .freeze          (freeze),
    .cpu             (cpu_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic eoi(input logic specific, input logic [2:0] lvl, input logic [2:0] rot);
    priority_rotate = rot;
    eoi_valid       = 1'b1;
    eoi_specific    = specific;
    eoi_level       = lvl;
    tick();
    eoi_valid = 1'b0;
  endtask

  // Full two-pulse acknowledge: INTA low 3 cycles, high 2, low 3.
  task automatic ack(input string tag, input logic [7:0] irq, input logic spur,
                     input logic eoi_now, input logic [2:0] eoi_lvl,
                     input logic [7:0] exp_isr_fall, input logic [7:0] exp_vec,
                     input logic [7:0] exp_isr_end);
    interrupt = irq;
    tick();
    check({tag, ":int_out"}, 32'(cpu_if.int_out), 32'd1);
    cpu_if.inta_n = 1'b0;
    if (spur) interrupt = 8'h00;
    if (eoi_now) begin
      eoi_valid    = 1'b1;
      eoi_specific = 1'b1;
      eoi_level    = eoi_lvl;
    end
    tick();
    eoi_valid = 1'b0;
    interrupt = 8'h00;
    check({tag, ":isr_fall"}, 32'(isr), 32'(exp_isr_fall));
    check({tag, ":clear_irr"}, 32'(clear_irr), spur ? 32'd0 : 32'(irq));
    check({tag, ":freeze"}, 32'(freeze), 32'd1);
    check({tag, ":int_drop"}, 32'(cpu_if.int_out), 32'd0);
    tick();
    check({tag, ":clear_pulse"}, 32'(clear_irr), 32'd0);
    tick();
    cpu_if.inta_n = 1'b1;
    tick();
    check({tag, ":oe_ack1"}, 32'(cpu_if.data_oe), 32'd0);
    tick();
    cpu_if.inta_n = 1'b0;
    tick();
    check({tag, ":oe_ack2"}, 32'(cpu_if.data_oe), 32'd1);
    check({tag, ":vector"}, 32'(cpu_if.data_out), 32'(exp_vec));
    tick();
    tick();
    cpu_if.inta_n = 1'b1;
    tick();
    check({tag, ":oe_end"}, 32'(cpu_if.data_oe), 32'd0);
    check({tag, ":freeze_end"}, 32'(freeze), 32'd0);
    check({tag, ":isr_end"}, 32'(isr), 32'(exp_isr_end));
  endtask

  initial begin
    rst_n           = 1'b0;
    interrupt       = 8'h00;
    priority_rotate = 3'd7;
    vector_base     = 5'b01000;
    auto_eoi        = 1'b0;
    eoi_valid       = 1'b0;
    eoi_specific    = 1'b0;
    eoi_level       = 3'd0;
    cpu_if.inta_n   = 1'b1;
    tick();
    tick();
    check("rst:int_out", 32'(cpu_if.int_out), 32'd0);
    check("rst:isr", 32'(isr), 32'd0);
    check("rst:data_oe", 32'(cpu_if.data_oe), 32'd0);
    check("rst:freeze", 32'(freeze), 32'd0);
    rst_n = 1'b1;
    tick();
    cpu_if.inta_n = 1'b0;
    tick();
    tick();
    check("idle_ignores_inta", 32'(freeze), 32'd0);
    cpu_if.inta_n = 1'b1;
    tick();
    tick();

    // Basic acknowledge, level 2 -> vector 0x42.
    ack("basic", 8'h04, 1'b0, 1'b0, 3'd0, 8'h04, 8'h42, 8'h04);
    eoi(1'b1, 3'd2, 3'd7);
    check("spec_eoi", 32'(isr), 32'd0);
    eoi(1'b0, 3'd0, 3'd7);
    check("nonspec_eoi_empty", 32'(isr), 32'd0);

    // Auto-EOI, level 7.
    auto_eoi = 1'b1;
    ack("aeoi", 8'h80, 1'b0, 1'b0, 3'd0, 8'h80, 8'h47, 8'h00);
    auto_eoi = 1'b0;

    // Non-specific EOI under rotation.
    ack("lvl1", 8'h02, 1'b0, 1'b0, 3'd0, 8'h02, 8'h41, 8'h02);
    ack("lvl5", 8'h20, 1'b0, 1'b0, 3'd0, 8'h22, 8'h45, 8'h22);
    eoi(1'b0, 3'd0, 3'd3);
    check("nseoi_rot3", 32'(isr), 32'h02);
    ack("lvl5b", 8'h20, 1'b0, 1'b0, 3'd0, 8'h22, 8'h45, 8'h22);
    eoi(1'b0, 3'd0, 3'd6);
    check("nseoi_rot6", 32'(isr), 32'h20);
    eoi(1'b1, 3'd5, 3'd7);
    check("clear5", 32'(isr), 32'd0);

    // Spurious with a live ISR bit 7 and auto-EOI on: bit 7 must survive.
    ack("lvl7", 8'h80, 1'b0, 1'b0, 3'd0, 8'h80, 8'h47, 8'h80);
    auto_eoi = 1'b1;
    ack("spur", 8'h10, 1'b1, 1'b0, 3'd0, 8'h80, 8'h47, 8'h80);
    auto_eoi = 1'b0;
    eoi(1'b1, 3'd7, 3'd7);
    check("clear7", 32'(isr), 32'd0);

    // Same-bit EOI/ack collision: the set wins.
    ack("coll_same", 8'h04, 1'b0, 1'b1, 3'd2, 8'h04, 8'h42, 8'h04);
    eoi(1'b1, 3'd2, 3'd7);
    // Different bits: both take effect together.
    ack("lvl3", 8'h08, 1'b0, 1'b0, 3'd0, 8'h08, 8'h43, 8'h08);
    ack("coll_diff", 8'h04, 1'b0, 1'b1, 3'd3, 8'h04, 8'h42, 8'h04);
    eoi(1'b1, 3'd2, 3'd7);

    // Asynchronous reset while the vector is being driven.
    interrupt = 8'h01;
    tick();
    cpu_if.inta_n = 1'b0;
    tick();
    interrupt = 8'h00;
    tick();
    cpu_if.inta_n = 1'b1;
    tick();
    tick();
    cpu_if.inta_n = 1'b0;
    tick();
    check("pre_rst:data_oe", 32'(cpu_if.data_oe), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst:data_oe", 32'(cpu_if.data_oe), 32'd0);
    check("async_rst:freeze", 32'(freeze), 32'd0);
    check("async_rst:int_out", 32'(cpu_if.int_out), 32'd0);
    check("async_rst:isr", 32'(isr), 32'd0);
    cpu_if.inta_n = 1'b1;
    interrupt     = 8'h02;
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst:int_out", 32'(cpu_if.int_out), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
